// File: rtl/tank_pkg.sv
// Shared select codes, fault bit indices and default sensor limits for the
// aquarium mode sequencer.
package tank_pkg;

    localparam logic [4:0] SEL_IDLE  = 5'b00000;
    localparam logic [4:0] SEL_COUNT = 5'b00001;
    localparam logic [4:0] SEL_CLEAN = 5'b00010;
    localparam logic [4:0] SEL_TEMP  = 5'b00100;
    localparam logic [4:0] SEL_FOOD  = 5'b01000;
    localparam logic [4:0] SEL_SALT  = 5'b10000;
    localparam logic [4:0] SEL_ERROR = 5'b11111;

    localparam int ERR_CLEAN = 0;
    localparam int ERR_TEMP  = 1;
    localparam int ERR_FOOD  = 2;
    localparam int ERR_SALT  = 3;
    localparam int NUM_SENSORS = 4;

    localparam logic [7:0] DEF_CLEAN_MIN = 8'd50;
    localparam logic [7:0] DEF_TEMP_MIN  = 8'd20;
    localparam logic [7:0] DEF_TEMP_MAX  = 8'd30;
    localparam logic [7:0] DEF_FOOD_MIN  = 8'd10;
    localparam logic [7:0] DEF_SALT_MIN  = 8'd30;
    localparam logic [7:0] DEF_SALT_MAX  = 8'd40;
    localparam logic [7:0] NO_MAX        = 8'hFF;

endpackage

// File: rtl/tank_range_check.sv
// Unsigned inclusive window check on one 8-bit sensor reading.
module tank_range_check (
    input  logic [7:0] value,
    input  logic [7:0] min_val,
    input  logic [7:0] max_val,
    output logic       fault
);
    assign fault = (value < min_val) || (value > max_val);
endmodule

// File: rtl/tank_mode_sequencer.sv
// Walks the output mux through counter and sensor modes, range-checks each
// sensor on its last dwell cycle and parks in error mode on any fault.
module tank_mode_sequencer
    import tank_pkg::*;
#(
    parameter int         DWELL_CYCLES = 4,
    parameter logic [7:0] CLEAN_MIN    = DEF_CLEAN_MIN,
    parameter logic [7:0] TEMP_MIN     = DEF_TEMP_MIN,
    parameter logic [7:0] TEMP_MAX     = DEF_TEMP_MAX,
    parameter logic [7:0] FOOD_MIN     = DEF_FOOD_MIN,
    parameter logic [7:0] SALT_MIN     = DEF_SALT_MIN,
    parameter logic [7:0] SALT_MAX     = DEF_SALT_MAX
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       enable,
    input  logic       err_ack,
    input  logic [7:0] tank_cleanliness,
    input  logic [7:0] tank_temperature,
    input  logic [7:0] tank_food_storage,
    input  logic [7:0] tank_saltiness,
    output logic [4:0] select,
    output logic [7:0] scan_count,
    output logic       sample_strobe,
    output logic [3:0] error_code,
    output logic       error_flag
);
    localparam int          DW   = $clog2(DWELL_CYCLES);
    localparam logic [DW-1:0] LAST = DW'(DWELL_CYCLES - 1);

    logic [DW-1:0] dwell;
    logic [NUM_SENSORS-1:0][7:0] val, lo, hi;
    logic [NUM_SENSORS-1:0] fault, fault_now;
    logic sensor_mode;

    assign val = {tank_saltiness, tank_food_storage, tank_temperature, tank_cleanliness};
    assign lo  = {SALT_MIN, FOOD_MIN, TEMP_MIN, CLEAN_MIN};
    assign hi  = {SALT_MAX, NO_MAX, TEMP_MAX, NO_MAX};

    assign sensor_mode = (select == SEL_CLEAN) || (select == SEL_TEMP) ||
                         (select == SEL_FOOD)  || (select == SEL_SALT);
    assign sample_strobe = sensor_mode && (dwell == LAST);
    assign error_flag    = (select == SEL_ERROR);

    // Sensor lane i is live only while select is the one-hot code SEL_CLEAN << i.
    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_chk
        tank_range_check u_chk (
            .value  (val[i]),
            .min_val(lo[i]),
            .max_val(hi[i]),
            .fault  (fault[i])
        );
        assign fault_now[i] = sample_strobe && fault[i] && (select == 5'(SEL_CLEAN << i));
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            select     <= SEL_IDLE;
            scan_count <= '0;
            error_code <= '0;
            dwell      <= '0;
        end else begin
            case (select)
                SEL_IDLE: begin
                    dwell <= '0;
                    if (enable) select <= SEL_COUNT;
                end
                SEL_ERROR: begin
                    dwell <= '0;
                    if (err_ack) begin
                        select     <= SEL_IDLE;
                        error_code <= '0;
                    end
                end
                SEL_COUNT, SEL_CLEAN, SEL_TEMP, SEL_FOOD, SEL_SALT: begin
                    if (!enable) begin
                        select     <= SEL_IDLE;
                        dwell      <= '0;
                        error_code <= '0;
                    end else if (dwell != LAST) begin
                        dwell <= dwell + 1'b1;
                    end else begin
                        dwell      <= '0;
                        error_code <= error_code | fault_now;
                        case (select)
                            SEL_COUNT: select <= SEL_CLEAN;
                            SEL_CLEAN: select <= SEL_TEMP;
                            SEL_TEMP:  select <= SEL_FOOD;
                            SEL_FOOD:  select <= SEL_SALT;
                            default: begin
                                // End of SALT: all four sensors have now been reported.
                                if ((error_code | fault_now) != '0) begin
                                    select <= SEL_ERROR;
                                end else begin
                                    select     <= SEL_COUNT;
                                    scan_count <= scan_count + 8'd1;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    select <= SEL_IDLE;
                    dwell  <= '0;
                end
            endcase
        end
    end
endmodule
